// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the loadable instruction memory:
//   state_t    : controller state encoding (LOAD while the image is written,
//                RUN while the fetch stage reads)
//   INSTR_W    : instruction word width
//   INSTR_NOP  : word returned in place of data on a faulting fetch
//                (addi x0, x0, 0)
// ---------------------------------------------------------------------------
package imem_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0013;

endpackage : imem_pkg

// File: rtl/imem_byte_ram.sv
// ---------------------------------------------------------------------------
// imem_byte_ram
// 2**ADDR_W x 8 byte array with one synchronous byte-write port and one
// combinational 4-byte little-endian read port. The read address wraps
// modulo the array depth, so a word starting near the top of memory pulls
// its upper bytes from the bottom.
//
// Ports:
//   clk    : rising-edge clock
//   we     : write wdata to waddr at the clock edge
//   waddr  : byte write address
//   wdata  : byte to write
//   raddr  : byte address of the least-significant byte of the word read
//   rdata  : {mem[raddr+3], mem[raddr+2], mem[raddr+1], mem[raddr]}
//
// The array has no reset: its contents survive a controller reset.
// ---------------------------------------------------------------------------
module imem_byte_ram
    import imem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // One read lane per byte of the instruction word; the ADDR_W-bit sum
    // provides the modulo-depth wrap for free.
    generate
        for (genvar gi = 0; gi < INSTR_W / 8; gi++) begin : g_lane
            logic [ADDR_W-1:0] lane_addr;
            assign lane_addr              = raddr + ADDR_W'(gi);
            assign rdata[gi*8 +: 8]       = mem[lane_addr];
        end
    endgenerate

endmodule : imem_byte_ram

// File: rtl/imem_loadable.sv
// ---------------------------------------------------------------------------
// imem_loadable
// Byte-addressed, little-endian instruction memory. After reset the program
// image is written one byte per cycle through the loader port; a load_done
// pulse switches to RUN, after which the memory is read-only and serves
// 32-bit fetches with one cycle of latency through a single response slot.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   load_en/addr/data : loader byte write (honoured only while loading)
//   load_done       : ends loading (a coincident write still lands)
//   loading         : high while in LOAD
//   fetch_req/pc    : fetch request, accepted when fetch_req && fetch_ready
//   fetch_ready     : slot free or being drained this cycle, and in RUN
//   instr_valid     : response slot holds a result
//   instr_ready     : consumer takes the response
//   instr           : fetched word, or NOP on a fault
//   fault_misalign  : pc not word aligned
//   fault_range     : pc beyond the decoded address space
// ---------------------------------------------------------------------------
module imem_loadable
    import imem_pkg::*;
#(
    parameter int ADDR_W        = 10,
    parameter int PC_W          = 32,
    parameter bit RESET_TO_LOAD = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic              load_done,
    output logic              loading,
    input  logic              fetch_req,
    input  logic [PC_W-1:0]   fetch_pc,
    output logic              fetch_ready,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic              fault_misalign,
    output logic              fault_range
);

    localparam state_t RESET_STATE = RESET_TO_LOAD ? ST_LOAD : ST_RUN;

    state_t state_reg, state_next;

    logic               valid_reg;
    logic [INSTR_W-1:0] instr_reg;
    logic               misalign_reg;
    logic               range_reg;

    logic               accept;
    logic               pc_misalign;
    logic               pc_range;
    logic [INSTR_W-1:0] ram_rdata;
    logic               ram_we;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= RESET_STATE;
        end else begin
            state_reg <= state_next;
        end
    end

    // LOAD -> RUN on load_done; RUN is left only through reset.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_LOAD: if (load_done) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = RESET_STATE;
        endcase
    end

    assign loading = (state_reg == ST_LOAD);

    // ---------------------------------------------------------------- RAM
    // The write is qualified on the current state, so a write coinciding
    // with load_done still lands before RUN begins.
    assign ram_we = load_en && (state_reg == ST_LOAD);

    imem_byte_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (fetch_pc[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    // -------------------------------------------------------- fault decode
    assign pc_misalign = (fetch_pc[1:0] != 2'b00);

    generate
        if (PC_W > ADDR_W) begin : g_range
            assign pc_range = |fetch_pc[PC_W-1:ADDR_W];
        end else begin : g_no_range
            assign pc_range = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------ response slot
    // The slot can refill in the same cycle it is consumed, which keeps
    // fetches running at one per cycle while the consumer accepts.
    assign fetch_ready = (state_reg == ST_RUN) && (!valid_reg || instr_ready);
    assign accept      = fetch_req && fetch_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg    <= 1'b0;
            instr_reg    <= '0;
            misalign_reg <= 1'b0;
            range_reg    <= 1'b0;
        end else if (accept) begin
            valid_reg    <= 1'b1;
            instr_reg    <= (pc_misalign || pc_range) ? INSTR_NOP : ram_rdata;
            misalign_reg <= pc_misalign;
            range_reg    <= pc_range;
        end else if (instr_ready) begin
            // Drained with no refill; data and flags keep their last values.
            valid_reg    <= 1'b0;
        end
    end

    assign instr_valid    = valid_reg;
    assign instr          = instr_reg;
    assign fault_misalign = misalign_reg;
    assign fault_range    = range_reg;

endmodule : imem_loadable

// File: tb/tb_imem_loadable.sv
// ---------------------------------------------------------------------------
// tb_imem_loadable
// Directed bench for imem_loadable (ADDR_W=10, PC_W=32, RESET_TO_LOAD=1).
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// the same point, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_imem_loadable;

    localparam int ADDR_W = 10;
    localparam int PC_W   = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W0  = 32'h0094_0333;
    localparam logic [31:0] W1  = 32'h4139_03b3;
    localparam logic [31:0] WT  = 32'h4433_2211;

    logic              clk;
    logic              reset;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        load_data;
    logic              load_done;
    logic              loading;
    logic              fetch_req;
    logic [PC_W-1:0]   fetch_pc;
    logic              fetch_ready;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic              fault_misalign;
    logic              fault_range;

    int tests_run  = 0;
    int tests_fail = 0;

    imem_loadable #(
        .ADDR_W        (ADDR_W),
        .PC_W          (PC_W),
        .RESET_TO_LOAD (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load_en        (load_en),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .load_done      (load_done),
        .loading        (loading),
        .fetch_req      (fetch_req),
        .fetch_pc       (fetch_pc),
        .fetch_ready    (fetch_ready),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .fault_misalign (fault_misalign),
        .fault_range    (fault_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_fail++;
            $display("[TB] FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full response check: valid, word, misalign flag, range flag.
    task automatic check_resp(input string tag, input logic [31:0] w,
                              input logic ma, input logic rg);
        check({tag, ".valid"},    32'(instr_valid),    32'd1);
        check({tag, ".instr"},    instr,               w);
        check({tag, ".misalign"}, 32'(fault_misalign), 32'(ma));
        check({tag, ".range"},    32'(fault_range),    32'(rg));
    endtask

    // Issue one fetch, wait for the response edge, drop the request.
    task automatic fetch_one(input logic [31:0] pc);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        step();
        fetch_req = 1'b0;
    endtask

    logic [ADDR_W-1:0] ld_addr_tab [12];
    logic [7:0]        ld_data_tab [12];

    initial begin
        ld_addr_tab = '{10'h000, 10'h001, 10'h002, 10'h003,
                        10'h004, 10'h005, 10'h006, 10'h007,
                        10'h3fc, 10'h3fd, 10'h3fe, 10'h3ff};
        ld_data_tab = '{8'h33, 8'h03, 8'h94, 8'h00,
                        8'hb3, 8'h03, 8'h39, 8'h41,
                        8'h11, 8'h22, 8'h33, 8'h44};

        reset       = 1'b1;
        load_en     = 1'b0;
        load_addr   = '0;
        load_data   = '0;
        load_done   = 1'b0;
        fetch_req   = 1'b0;
        fetch_pc    = '0;
        instr_ready = 1'b1;
        step();
        step();

        // Reset state
        check("rst.loading",  32'(loading),        32'd1);
        check("rst.valid",    32'(instr_valid),    32'd0);
        check("rst.instr",    instr,               32'd0);
        check("rst.misalign", 32'(fault_misalign), 32'd0);
        check("rst.range",    32'(fault_range),    32'd0);
        reset = 1'b0;

        // Fetch held during LOAD: never accepted. The final byte write
        // coincides with load_done.
        fetch_req = 1'b1;
        fetch_pc  = 32'h0;
        #1;
        check("load.fetch_ready", 32'(fetch_ready), 32'd0);
        for (int i = 0; i < 12; i++) begin
            load_en   = 1'b1;
            load_addr = ld_addr_tab[i];
            load_data = ld_data_tab[i];
            load_done = (i == 11);
            step();
            check("load.valid_low", 32'(instr_valid), 32'd0);
        end
        load_en   = 1'b0;
        load_done = 1'b0;

        // First RUN cycle: the pending request is accepted immediately.
        check("run.loading",     32'(loading),     32'd0);
        check("run.fetch_ready", 32'(fetch_ready), 32'd1);
        step();
        fetch_pc = 32'h4;
        check_resp("b2b.pc0", W0, 1'b0, 1'b0);
        check("b2b.fetch_ready", 32'(fetch_ready), 32'd1);
        step();
        fetch_req = 1'b0;
        check_resp("b2b.pc4", W1, 1'b0, 1'b0);
        step();
        check("drain.valid", 32'(instr_valid), 32'd0);

        // Fault cases and the top-of-memory boundary
        fetch_one(32'h2);
        check_resp("mis.pc2", NOP, 1'b1, 1'b0);
        fetch_one(32'h400);
        check_resp("rng.pc400", NOP, 1'b0, 1'b1);
        fetch_one(32'h402);
        check_resp("both.pc402", NOP, 1'b1, 1'b1);
        fetch_one(32'h3fc);
        check_resp("top.pc3fc", WT, 1'b0, 1'b0);
        fetch_one(32'h3fe);
        check_resp("top.pc3fe", NOP, 1'b1, 1'b0);
        step();

        // Backpressure: slot holds for 3 cycles, then refills on release.
        instr_ready = 1'b0;
        fetch_one(32'h0);
        fetch_req = 1'b1;
        fetch_pc  = 32'h4;
        for (int i = 0; i < 3; i++) begin
            check_resp("bp.hold", W0, 1'b0, 1'b0);
            check("bp.fetch_ready", 32'(fetch_ready), 32'd0);
            step();
        end
        instr_ready = 1'b1;
        #1;
        check("bp.release_ready", 32'(fetch_ready), 32'd1);
        step();
        fetch_req = 1'b0;
        check_resp("bp.refill", W1, 1'b0, 1'b0);
        step();

        // Loader writes are ignored in RUN.
        load_en   = 1'b1;
        load_addr = 10'h000;
        load_data = 8'hff;
        load_done = 1'b1;
        step();
        load_en   = 1'b0;
        load_done = 1'b0;
        fetch_one(32'h0);
        check_resp("ro.pc0", W0, 1'b0, 1'b0);
        check("ro.loading", 32'(loading), 32'd0);

        // Reset with a pending response; memory survives.
        instr_ready = 1'b0;
        fetch_one(32'h4);
        check("prst.valid", 32'(instr_valid), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("prst.valid_cleared", 32'(instr_valid), 32'd0);
        check("prst.loading",       32'(loading),     32'd1);
        instr_ready = 1'b1;
        load_done   = 1'b1;
        step();
        load_done = 1'b0;
        fetch_one(32'h4);
        check_resp("retain.pc4", W1, 1'b0, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule : tb_imem_loadable
